// File: rtl/c1355_resp_misr.sv
// Response compactor for the c1355 core: folds 32 registered core outputs per clock into a MISR
// over a programmable window and compares the result with a golden signature. Optional x-masking via C1355_MISR_XMASK_EN.
module c1355_resp_misr #(
    parameter int                WIDTH       = 32,
    parameter int                COUNT_W     = 16,
    parameter int                SKIP_CYCLES = 2,
    parameter logic [WIDTH-1:0]  POLY        = 32'h04C11DB7,
    parameter logic [WIDTH-1:0]  SEED        = 32'hFFFFFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [COUNT_W-1:0] num_cycles,
    input  logic [WIDTH-1:0]   resp_in,
`ifdef C1355_MISR_XMASK_EN
    input  logic [WIDTH-1:0]   x_mask,
`endif
    input  logic [WIDTH-1:0]   golden,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [WIDTH-1:0]   signature,
    output logic [COUNT_W-1:0] cycle_count,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_COMPACT, S_DONE} state_t;

    localparam int SKIP_W = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;
    localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'((SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sig_q, sig_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] num_q, num_d;
    logic [SKIP_W-1:0]  skip_q, skip_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   resp_eff;
    logic [WIDTH-1:0]   misr_next;

`ifdef C1355_MISR_XMASK_EN
    assign resp_eff = resp_in & ~x_mask;
`else
    assign resp_eff = resp_in;
`endif

    assign misr_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ resp_eff;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        skip_d  = skip_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE re-arms exactly like IDLE so back-to-back runs need no idle gap.
                if (start) begin
                    num_d  = num_cycles;
                    sig_d  = SEED;
                    cnt_d  = '0;
                    skip_d = SKIP_INIT;
                    if (num_cycles == '0)
                        state_d = S_DONE;
                    else if (SKIP_CYCLES > 0)
                        state_d = S_SKIP;
                    else
                        state_d = S_COMPACT;
                end
            end
            S_SKIP: begin
                if (skip_q == '0)
                    state_d = S_COMPACT;
                else
                    skip_d = skip_q - SKIP_W'(1);
            end
            S_COMPACT: begin
                sig_d = misr_next;
                cnt_d = cnt_q + COUNT_W'(1);
                if (cnt_d == num_q)
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            sig_d   = SEED;
            cnt_d   = '0;
        end
        busy_d = (state_d == S_SKIP) || (state_d == S_COMPACT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            num_q   <= '0;
            skip_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            skip_q  <= skip_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Golden is live, so pass follows it while the registered signature is held in DONE.
    assign pass        = done_q && (sig_q == golden);
    assign busy        = busy_q;
    assign done        = done_q;
    assign signature   = sig_q;
    assign cycle_count = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_c1355_resp_misr.sv
// Self-checking bench for c1355_resp_misr: directed vectors plus randomized runs against a behavioural MISR model.
// Build with +define+C1355_MISR_XMASK_EN to also cover the x_mask build.
module tb_c1355_resp_misr;

    localparam int          WIDTH = 32;
    localparam int          CW    = 16;
    localparam int          SKIP  = 2;
    localparam logic [31:0] POLY  = 32'h04C11DB7;
    localparam logic [31:0] SEED  = 32'hFFFFFFFF;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] num_cycles = '0;
    logic [31:0]   resp_in = '0;
    logic [31:0]   golden = '0;
    logic [31:0]   x_mask = '0;
    logic          busy, done, pass;
    logic [31:0]   signature;
    logic [CW-1:0] cycle_count;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    c1355_resp_misr dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .num_cycles(num_cycles), .resp_in(resp_in),
`ifdef C1355_MISR_XMASK_EN
        .x_mask(x_mask),
`endif
        .golden(golden), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .cycle_count(cycle_count), .dbg_state(dbg_state)
    );

    // Reference: signature update written straight from the polynomial definition.
    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] r);
        logic [31:0] fb;
        fb = s[31] ? POLY : 32'h0;
        return (s << 1) ^ fb ^ r;
    endfunction

    // Inputs change and outputs are sampled on the falling edge, half a period from the active edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [CW-1:0] n);
        start = 1'b1;
        num_cycles = n;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        n_checks++; if ({busy, done, pass} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {busy, done, pass}); else n_pass++;
        n_checks++; if (signature !== SEED) $display("FAIL reset_sig got %h exp %h", signature, SEED); else n_pass++;
        n_checks++; if (cycle_count !== '0) $display("FAIL reset_cnt got %0d exp 0", cycle_count); else n_pass++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_vectors();
        // Window of one with resp=1 held.
        resp_in = 32'h1;
        pulse_start(1);
        for (int k = 1; k <= SKIP + 1; k++) begin
            n_checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL v1_busy k=%0d got busy=%b done=%b exp 1 0", k, busy, done); else n_pass++;
            step();
        end
        golden = 32'hFB3EE248;
        #1;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL v1_done got done=%b busy=%b exp 1 0", done, busy); else n_pass++;
        n_checks++; if (signature !== 32'hFB3EE248) $display("FAIL v1_sig got %h exp fb3ee248", signature); else n_pass++;
        n_checks++; if (pass !== 1'b1) $display("FAIL v1_pass got %b exp 1", pass); else n_pass++;
        // Window of two with resp=0; restarted directly from DONE.
        resp_in = 32'h0;
        @(negedge clk);
        pulse_start(2);
        for (int k = 1; k <= SKIP + 1; k++) step();
        n_checks++; if (signature !== 32'hFB3EE249) $display("FAIL v2_sig1 got %h exp fb3ee249", signature); else n_pass++;
        n_checks++; if (cycle_count !== 16'd1) $display("FAIL v2_cnt1 got %0d exp 1", cycle_count); else n_pass++;
        step();
        n_checks++; if (signature !== 32'hF2BCD925 || done !== 1'b1) $display("FAIL v2_sig2 got %h done=%b exp f2bcd925 1", signature, done); else n_pass++;
        n_checks++; if (cycle_count !== 16'd2) $display("FAIL v2_cnt2 got %0d exp 2", cycle_count); else n_pass++;
    endtask

    task automatic test_zero_window();
        abort = 1'b1; step(); abort = 1'b0;
        start = 1'b1; num_cycles = '0;
        n_checks++; if (busy !== 1'b0) $display("FAIL z_busy0 got %b exp 0", busy); else n_pass++;
        step();
        start = 1'b0;
        golden = SEED;
        #1;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL z_done got done=%b busy=%b exp 1 0", done, busy); else n_pass++;
        n_checks++; if (signature !== SEED || pass !== 1'b1) $display("FAIL z_pass1 got sig=%h pass=%b exp ffffffff 1", signature, pass); else n_pass++;
        golden = 32'h0;
        #1;
        n_checks++; if (pass !== 1'b0) $display("FAIL z_pass0 got %b exp 0", pass); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random_runs();
        logic [31:0] exp_q[$];
        logic [31:0] model;
        int n;
        for (int run = 0; run < 8; run++) begin
            n = $urandom_range(1, 12);
            exp_q.delete();
            pulse_start(CW'(n));
            model = SEED;
            for (int k = 1; k <= SKIP + n; k++) begin
                resp_in = $urandom;
                if (k > SKIP) begin
                    model = ref_step(model, resp_in);
                    exp_q.push_back(model);
                end
                if (busy !== 1'b1) begin
                    n_checks++; $display("FAIL rnd_busy run=%0d k=%0d got 0 exp 1", run, k);
                end
                step();
                if (k > SKIP) begin
                    n_checks++;
                    if (signature !== exp_q[0] || cycle_count !== CW'(k - SKIP))
                        $display("FAIL rnd_sig run=%0d k=%0d got %h/%0d exp %h/%0d", run, k, signature, cycle_count, exp_q[0], k - SKIP);
                    else n_pass++;
                    void'(exp_q.pop_front());
                end
            end
            golden = model;
            #1;
            n_checks++; if (done !== 1'b1 || pass !== 1'b1) $display("FAIL rnd_done run=%0d got done=%b pass=%b exp 1 1", run, done, pass); else n_pass++;
            golden = model ^ (32'h1 << $urandom_range(0, 31));
            #1;
            n_checks++; if (pass !== 1'b0) $display("FAIL rnd_nopass run=%0d got %b exp 0", run, pass); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] model;
        model = SEED;
        pulse_start(10);
        for (int k = 1; k <= SKIP + 10; k++) begin
            resp_in = $urandom;
            if (k > SKIP) model = ref_step(model, resp_in);
            start = (k == SKIP + 4) || (k == 1);
            num_cycles = 3;
            if (k == SKIP + 10) begin
                n_checks++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL ign_early got done=%b busy=%b exp 0 1", done, busy); else n_pass++;
            end
            step();
        end
        start = 1'b0;
        n_checks++; if (done !== 1'b1 || cycle_count !== 16'd10) $display("FAIL ign_done got done=%b cnt=%0d exp 1 10", done, cycle_count); else n_pass++;
        n_checks++; if (signature !== model) $display("FAIL ign_sig got %h exp %h", signature, model); else n_pass++;
        abort = 1'b1; step(); abort = 1'b0;
        n_checks++; if ({busy, done} !== 2'b00 || signature !== SEED || cycle_count !== '0)
            $display("FAIL ign_abort got busy=%b done=%b sig=%h cnt=%0d exp 0 0 ffffffff 0", busy, done, signature, cycle_count); else n_pass++;
    endtask

    task automatic test_start_abort_same();
        start = 1'b1; abort = 1'b1; num_cycles = 5;
        step();
        start = 1'b0; abort = 1'b0;
        step();
        n_checks++; if ({busy, done} !== 2'b00 || signature !== SEED) $display("FAIL sa_idle got busy=%b done=%b sig=%h exp 0 0 ffffffff", busy, done, signature); else n_pass++;
    endtask

    task automatic test_abort_mid_run();
        pulse_start(8);
        for (int k = 0; k < SKIP + 3; k++) begin resp_in = $urandom; step(); end
        abort = 1'b1; step(); abort = 1'b0;
        step();
        n_checks++; if ({busy, done} !== 2'b00 || signature !== SEED || cycle_count !== '0)
            $display("FAIL am_idle got busy=%b done=%b sig=%h cnt=%0d exp 0 0 ffffffff 0", busy, done, signature, cycle_count); else n_pass++;
    endtask

    task automatic test_async_reset();
        pulse_start(20);
        for (int k = 0; k < SKIP + 4; k++) begin resp_in = $urandom | 32'h1; step(); end
        n_checks++; if (busy !== 1'b1 || cycle_count !== 16'd4) $display("FAIL ar_pre got busy=%b cnt=%0d exp 1 4", busy, cycle_count); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++; if ({busy, done, pass} !== 3'b000 || signature !== SEED || cycle_count !== '0)
            $display("FAIL ar_async got flags=%b sig=%h cnt=%0d exp 000 ffffffff 0", {busy, done, pass}, signature, cycle_count); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        step();
        n_checks++; if ({busy, done} !== 2'b00) $display("FAIL ar_after got busy=%b done=%b exp 0 0", busy, done); else n_pass++;
    endtask

`ifdef C1355_MISR_XMASK_EN
    task automatic test_xmask();
        x_mask = 32'hFFFFFFFF;
        resp_in = $urandom;
        pulse_start(1);
        for (int k = 0; k < SKIP + 1; k++) step();
        n_checks++; if (signature !== 32'hFB3EE249) $display("FAIL xm_sig got %h exp fb3ee249", signature); else n_pass++;
        x_mask = 32'h0;
    endtask
`endif

    initial begin
        test_reset();
        test_vectors();
        test_zero_window();
        test_random_runs();
        test_start_ignored();
        test_start_abort_same();
        test_abort_mid_run();
        test_async_reset();
`ifdef C1355_MISR_XMASK_EN
        test_xmask();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
